// File: rtl/vending_pkg.sv
// Shared encodings for the vending controller: estados bus, coin codes and the
// payment-side FSM states.
package vending_pkg;

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    PRODUTO    = 2'b01,
    COMPARADOR = 2'b10,
    INVALIDO   = 2'b11
  } estados_t;

  typedef enum logic [1:0] {
    MOEDA_5  = 2'b00,
    MOEDA_10 = 2'b01,
    MOEDA_25 = 2'b10,
    MOEDA_50 = 2'b11
  } moeda_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COLETA = 3'd1,
    LIBERA = 3'd2,
    TROCO  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam int VALOR_W = 6;

  // Face value in centavos of a coin code (same code for inserted and change coins).
  function automatic logic [VALOR_W-1:0] valor_moeda(input logic [1:0] tipo);
    case (tipo)
      2'b00:   return 6'd5;
      2'b01:   return 6'd10;
      2'b10:   return 6'd25;
      default: return 6'd50;
    endcase
  endfunction

endpackage

// File: rtl/comparador_pagamento_temporizador.sv
// Inactivity counter: cleared on activity, counts while enabled, flags the last
// idle cycle before the automatic refund.
module temporizador_inatividade #(
  parameter int CICLOS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpar,
  input  logic habilitar,
  output logic fimContagem
);

  localparam int TW = $clog2(CICLOS + 1);

  logic [TW-1:0] contagem;

  // Saturates at the terminal value; the owner leaves COLETA on that cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (limpar) begin
      contagem <= '0;
    end else if (habilitar && !fimContagem) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fimContagem = (contagem == TW'(CICLOS - 1));

endmodule

// File: rtl/comparador_pagamento.sv
// Payment side of the vending protocol: collects coins while the controller sits
// in COMPARADOR, releases the product, pays change greedily and pulses OK.
module comparador_pagamento
  import vending_pkg::*;
#(
  parameter int PRECO_W        = 8,
  parameter int CREDITO_W      = 10,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           estados,
  input  logic [PRECO_W-1:0]   preco,
  input  logic                 moeda_valid,
  input  logic [1:0]           moeda_tipo,
  input  logic                 cancelar,
  input  logic                 troco_ready,
  output logic [CREDITO_W-1:0] credito,
  output logic                 liberar_produto,
  output logic                 troco_valid,
  output logic [1:0]           troco_tipo,
  output logic                 moeda_rejeitada,
  output logic                 OK,
  output logic                 ocupado
);

  // Common width wide enough for credit, price and credit+coin without overflow.
  localparam int LW = ((CREDITO_W > PRECO_W) ? CREDITO_W : PRECO_W) + 1;
  localparam logic [LW-1:0] CREDITO_MAX = LW'((2 ** CREDITO_W) - 1);

  estado_t              estado;
  logic [PRECO_W-1:0]   precoReg;
  logic [CREDITO_W-1:0] trocoReg;

  logic [LW-1:0] creditoExt;
  logic [LW-1:0] precoExt;
  logic [LW-1:0] trocoExt;
  logic [LW-1:0] valorMoeda;
  logic [LW-1:0] valorTroco;
  logic [LW-1:0] somaMoeda;
  logic          moedaCabe;
  logic          compra;
  logic          aborto;
  logic          timerClear;
  logic          timerEnable;
  logic          timeout;
  logic [1:0]    tipoGuloso;

  always_comb begin
    creditoExt = LW'(credito);
    precoExt   = LW'(precoReg);
    trocoExt   = LW'(trocoReg);
    valorMoeda = LW'(valor_moeda(moeda_tipo));
    valorTroco = LW'(valor_moeda(troco_tipo));
    somaMoeda  = creditoExt + valorMoeda;
    moedaCabe  = (somaMoeda <= CREDITO_MAX);

    compra = (estado == COLETA) && (creditoExt >= precoExt);
    aborto = (estado == COLETA) && !compra &&
             (cancelar || timeout || (estados != COMPARADOR));

    timerClear  = (estado == IDLE) ||
                  ((estado == COLETA) && !compra && !aborto && moeda_valid && moedaCabe);
    timerEnable = (estado == COLETA) && !compra && !aborto && !moeda_valid;

    // Greedy change: largest coin not exceeding the remaining change.
    if (trocoExt >= LW'(valor_moeda(MOEDA_50))) begin
      tipoGuloso = MOEDA_50;
    end else if (trocoExt >= LW'(valor_moeda(MOEDA_25))) begin
      tipoGuloso = MOEDA_25;
    end else if (trocoExt >= LW'(valor_moeda(MOEDA_10))) begin
      tipoGuloso = MOEDA_10;
    end else begin
      tipoGuloso = MOEDA_5;
    end
  end

  temporizador_inatividade #(
    .CICLOS(TIMEOUT_CICLOS)
  ) uTemporizador (
    .clk        (clk),
    .rst_n      (rst_n),
    .limpar     (timerClear),
    .habilitar  (timerEnable),
    .fimContagem(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= IDLE;
      precoReg        <= '0;
      trocoReg        <= '0;
      credito         <= '0;
      liberar_produto <= 1'b0;
      troco_valid     <= 1'b0;
      troco_tipo      <= 2'b00;
      moeda_rejeitada <= 1'b0;
      OK              <= 1'b0;
      ocupado         <= 1'b0;
    end else begin
      liberar_produto <= 1'b0;
      moeda_rejeitada <= 1'b0;
      OK              <= 1'b0;

      // Coins are only accepted while collecting; everywhere else they bounce.
      if (moeda_valid && (estado != COLETA)) begin
        moeda_rejeitada <= 1'b1;
      end

      case (estado)
        IDLE: begin
          if (estados == COMPARADOR) begin
            estado   <= COLETA;
            precoReg <= preco;
            credito  <= '0;
            ocupado  <= 1'b1;
          end else begin
            ocupado <= 1'b0;
          end
        end

        COLETA: begin
          if (compra) begin
            trocoReg        <= CREDITO_W'(creditoExt - precoExt);
            credito         <= '0;
            liberar_produto <= 1'b1;
            estado          <= LIBERA;
            if (moeda_valid) begin
              moeda_rejeitada <= 1'b1;
            end
          end else if (aborto) begin
            trocoReg <= credito;
            credito  <= '0;
            estado   <= TROCO;
            if (moeda_valid) begin
              moeda_rejeitada <= 1'b1;
            end
          end else if (moeda_valid) begin
            if (moedaCabe) begin
              credito <= CREDITO_W'(somaMoeda);
            end else begin
              moeda_rejeitada <= 1'b1;
            end
          end
        end

        LIBERA: begin
          estado <= TROCO;
        end

        TROCO: begin
          if (troco_valid) begin
            if (troco_ready) begin
              trocoReg    <= CREDITO_W'(trocoExt - valorTroco);
              troco_valid <= 1'b0;
            end
          end else if (trocoExt < LW'(valor_moeda(MOEDA_5))) begin
            estado <= FIM;
            OK     <= 1'b1;
          end else begin
            troco_valid <= 1'b1;
            troco_tipo  <= tipoGuloso;
          end
        end

        FIM: begin
          estado  <= IDLE;
          ocupado <= 1'b0;
        end

        default: begin
          estado  <= IDLE;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_pagamento.sv
// Directed bench for comparador_pagamento: transaction table plus hand-written
// latency, timeout, saturation and reset sequences.
module tb_comparador_pagamento;
  import vending_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] estados;
  logic [7:0] preco;
  logic       moeda_valid;
  logic [1:0] moeda_tipo;
  logic       cancelar;
  logic       troco_ready;
  logic [9:0] credito;
  logic       liberar_produto, troco_valid, moeda_rejeitada, OK, ocupado;
  logic [1:0] troco_tipo;

  logic [1:0] bEstados;
  logic [7:0] bPreco;
  logic       bMoedaValid;
  logic [1:0] bMoedaTipo;
  logic       bCancelar;
  logic       bTrocoReady;
  logic [5:0] bCredito;
  logic       bLiberar, bTrocoValid, bRej, bOk, bOcupado;
  logic [1:0] bTrocoTipo;

  comparador_pagamento #(.PRECO_W(8), .CREDITO_W(10), .TIMEOUT_CICLOS(8)) dutA (
    .clk(clk), .rst_n(rst_n), .estados(estados), .preco(preco),
    .moeda_valid(moeda_valid), .moeda_tipo(moeda_tipo), .cancelar(cancelar),
    .troco_ready(troco_ready), .credito(credito), .liberar_produto(liberar_produto),
    .troco_valid(troco_valid), .troco_tipo(troco_tipo), .moeda_rejeitada(moeda_rejeitada),
    .OK(OK), .ocupado(ocupado)
  );

  comparador_pagamento #(.PRECO_W(8), .CREDITO_W(6), .TIMEOUT_CICLOS(8)) dutB (
    .clk(clk), .rst_n(rst_n), .estados(bEstados), .preco(bPreco),
    .moeda_valid(bMoedaValid), .moeda_tipo(bMoedaTipo), .cancelar(bCancelar),
    .troco_ready(bTrocoReady), .credito(bCredito), .liberar_produto(bLiberar),
    .troco_valid(bTrocoValid), .troco_tipo(bTrocoTipo), .moeda_rejeitada(bRej),
    .OK(bOk), .ocupado(bOcupado)
  );

  typedef struct packed {
    logic [7:0]      preco;
    logic [2:0]      nMoedas;
    logic [3:0][1:0] moedas;
    logic            cancela;
    logic [3:0]      atraso;
    logic            expLib;
    logic [2:0]      nTroco;
    logic [3:0][1:0] troco;
  } vec_t;

  vec_t       tabela [8];
  int         checks = 0;
  int         errors = 0;
  int         libCount;
  int         atraso;
  int         holdCnt;
  logic [1:0] tipoVisto;
  logic [1:0] trocoQ [$];

  function automatic void chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endfunction

  function automatic vec_t mk(input int p, input int n, input logic [1:0] m0, m1, m2, m3,
                              input int canc, input int atr, input int lib, input int nt,
                              input logic [1:0] t0, t1, t2, t3);
    vec_t v;
    v.preco   = 8'(p);
    v.nMoedas = 3'(n);
    v.moedas  = {m3, m2, m1, m0};
    v.cancela = canc[0];
    v.atraso  = 4'(atr);
    v.expLib  = lib[0];
    v.nTroco  = 3'(nt);
    v.troco   = {t3, t2, t1, t0};
    return v;
  endfunction

  // Coin dispenser model: waits atraso cycles, checks the offered coin is held stable.
  initial begin
    troco_ready = 1'b0;
    holdCnt     = 0;
    forever begin
      @(posedge clk);
      #2;
      if (troco_ready) begin
        troco_ready = 1'b0;
        holdCnt     = 0;
        chk("troco_valid_cai", int'(troco_valid), 0);
      end else if (troco_valid) begin
        if (holdCnt == 0) tipoVisto = troco_tipo;
        else chk("troco_tipo_estavel", int'(troco_tipo), int'(tipoVisto));
        if (holdCnt >= atraso) begin
          troco_ready = 1'b1;
          trocoQ.push_back(troco_tipo);
        end else begin
          holdCnt++;
        end
      end else begin
        holdCnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (liberar_produto) libCount++;
  endtask

  task automatic moeda(input logic [1:0] tipo);
    moeda_valid = 1'b1;
    moeda_tipo  = tipo;
    step();
    moeda_valid = 1'b0;
  endtask

  task automatic wait_ok(input int limite, output int ciclos);
    ciclos = -1;
    for (int i = 1; i <= limite; i++) begin
      step();
      if (OK) begin
        ciclos  = i;
        estados = ESPERA;
        break;
      end
    end
    chk("ok_visto", int'(ciclos > 0), 1);
    step();
    chk("ok_um_ciclo", int'(OK), 0);
    chk("ocupado_idle", int'(ocupado), 0);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int c;
    trocoQ.delete();
    libCount = 0;
    atraso   = int'(v.atraso);
    preco    = v.preco;
    estados  = COMPARADOR;
    step();
    chk("ocupado_coleta", int'(ocupado), 1);
    for (int i = 0; i < int'(v.nMoedas); i++) begin
      moeda(v.moedas[i]);
      chk("moeda_aceita", int'(moeda_rejeitada), 0);
    end
    if (v.cancela) begin
      cancelar = 1'b1;
      step();
      cancelar = 1'b0;
    end
    wait_ok(100, c);
    chk("credito_fim", int'(credito), 0);
    chk("liberar_qtd", libCount, int'(v.expLib));
    chk("troco_qtd", trocoQ.size(), int'(v.nTroco));
    for (int i = 0; i < int'(v.nTroco) && i < trocoQ.size(); i++)
      chk("troco_moeda", int'(trocoQ[i]), int'(v.troco[i]));
    $display("txn %0d preco=%0d liberar=%0d trocos=%0d ok_ciclos=%0d",
             idx, v.preco, libCount, trocoQ.size(), c);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; estados = ESPERA; preco = '0; moeda_valid = 1'b0; moeda_tipo = '0;
    cancelar = 1'b0; atraso = 0; libCount = 0;
    bEstados = ESPERA; bPreco = '0; bMoedaValid = 1'b0; bMoedaTipo = '0;
    bCancelar = 1'b0; bTrocoReady = 1'b1;

    tabela[0] = mk(75,  2, MOEDA_50, MOEDA_25, MOEDA_5, MOEDA_5, 0, 0, 1, 0,
                   MOEDA_5, MOEDA_5, MOEDA_5, MOEDA_5);
    tabela[1] = mk(65,  2, MOEDA_50, MOEDA_50, MOEDA_5, MOEDA_5, 0, 3, 1, 2,
                   MOEDA_25, MOEDA_10, MOEDA_5, MOEDA_5);
    tabela[2] = mk(0,   0, MOEDA_5, MOEDA_5, MOEDA_5, MOEDA_5, 0, 0, 1, 0,
                   MOEDA_5, MOEDA_5, MOEDA_5, MOEDA_5);
    tabela[3] = mk(255, 2, MOEDA_10, MOEDA_25, MOEDA_5, MOEDA_5, 1, 1, 0, 2,
                   MOEDA_25, MOEDA_10, MOEDA_5, MOEDA_5);
    tabela[4] = mk(100, 2, MOEDA_50, MOEDA_50, MOEDA_5, MOEDA_5, 0, 0, 1, 0,
                   MOEDA_5, MOEDA_5, MOEDA_5, MOEDA_5);
    tabela[5] = mk(35,  1, MOEDA_50, MOEDA_5, MOEDA_5, MOEDA_5, 0, 2, 1, 2,
                   MOEDA_10, MOEDA_5, MOEDA_5, MOEDA_5);
    tabela[6] = mk(195, 4, MOEDA_50, MOEDA_50, MOEDA_50, MOEDA_50, 0, 0, 1, 1,
                   MOEDA_5, MOEDA_5, MOEDA_5, MOEDA_5);
    tabela[7] = mk(255, 3, MOEDA_50, MOEDA_50, MOEDA_5, MOEDA_5, 1, 0, 0, 3,
                   MOEDA_50, MOEDA_50, MOEDA_5, MOEDA_5);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_credito", int'(credito), 0);
    chk("reset_liberar", int'(liberar_produto), 0);
    chk("reset_troco_valid", int'(troco_valid), 0);
    chk("reset_rejeitada", int'(moeda_rejeitada), 0);
    chk("reset_ok", int'(OK), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Coin while idle bounces for exactly one cycle.
    moeda(MOEDA_25);
    chk("idle_rejeitada", int'(moeda_rejeitada), 1);
    chk("idle_credito", int'(credito), 0);
    step();
    chk("idle_rejeitada_pulso", int'(moeda_rejeitada), 0);
    $display("seq idle_coin done");

    // Exact latency: coin -> liberar 2 cycles; coin during compare cycle bounces.
    trocoQ.delete(); libCount = 0; atraso = 0; preco = 75; estados = COMPARADOR;
    step();
    moeda(MOEDA_50);
    moeda(MOEDA_25);
    chk("lat_credito", int'(credito), 75);
    chk("lat_liberar_cedo", int'(liberar_produto), 0);
    moeda(MOEDA_5);
    chk("lat_liberar", int'(liberar_produto), 1);
    chk("lat_rejeitada", int'(moeda_rejeitada), 1);
    chk("lat_credito_zero", int'(credito), 0);
    step();
    chk("lat_liberar_pulso", int'(liberar_produto), 0);
    step();
    chk("lat_ok", int'(OK), 1);
    chk("lat_sem_troco", int'(troco_valid), 0);
    estados = ESPERA;
    step();
    chk("lat_ok_pulso", int'(OK), 0);
    chk("lat_ocupado", int'(ocupado), 0);
    chk("lat_troco_qtd", trocoQ.size(), 0);
    $display("seq latency liberar=%0d", libCount);

    for (int i = 0; i < 8; i++) run_txn(tabela[i], i);

    // Timeout with 10 centavos of credit.
    trocoQ.delete(); libCount = 0; atraso = 0; preco = 100; estados = COMPARADOR;
    step();
    moeda(MOEDA_10);
    repeat (7) step();
    chk("timeout_credito_antes", int'(credito), 10);
    step();
    chk("timeout_credito_zero", int'(credito), 0);
    chk("timeout_ocupado", int'(ocupado), 1);
    wait_ok(40, c);
    chk("timeout_troco_qtd", trocoQ.size(), 1);
    if (trocoQ.size() > 0) chk("timeout_troco_moeda", int'(trocoQ[0]), int'(MOEDA_10));
    chk("timeout_liberar", libCount, 0);
    $display("seq timeout_refund trocos=%0d", trocoQ.size());

    // Timeout with no credit: OK with no change.
    trocoQ.delete(); estados = COMPARADOR;
    step();
    wait_ok(30, c);
    chk("timeout_vazio_latencia", c, 9);
    chk("timeout_vazio_troco", trocoQ.size(), 0);
    $display("seq timeout_empty ok_ciclos=%0d", c);

    // Controller leaving COMPARADOR mid-collection aborts with full refund.
    trocoQ.delete(); libCount = 0; preco = 100; estados = COMPARADOR;
    step();
    moeda(MOEDA_25);
    estados = ESPERA;
    step();
    chk("abort_credito", int'(credito), 0);
    wait_ok(40, c);
    chk("abort_troco_qtd", trocoQ.size(), 1);
    if (trocoQ.size() > 0) chk("abort_troco_moeda", int'(trocoQ[0]), int'(MOEDA_25));
    chk("abort_liberar", libCount, 0);
    $display("seq abort trocos=%0d", trocoQ.size());

    // Saturation on the 6-bit credit instance.
    bMoedaValid = 1'b1; bMoedaTipo = MOEDA_50;
    step();
    bMoedaValid = 1'b0;
    chk("b_idle_rejeitada", int'(bRej), 1);
    chk("b_idle_credito", int'(bCredito), 0);
    bPreco = 60; bEstados = COMPARADOR;
    step();
    bMoedaValid = 1'b1; bMoedaTipo = MOEDA_50;
    step();
    chk("b_credito_50", int'(bCredito), 50);
    chk("b_aceita", int'(bRej), 0);
    bMoedaTipo = MOEDA_25;
    step();
    chk("sat_rejeitada", int'(bRej), 1);
    chk("sat_credito", int'(bCredito), 50);
    bMoedaTipo = MOEDA_10;
    step();
    bMoedaValid = 1'b0;
    chk("b_credito_60", int'(bCredito), 60);
    step();
    chk("b_liberar", int'(bLiberar), 1);
    repeat (2) step();
    chk("b_ok", int'(bOk), 1);
    chk("b_sem_troco", int'(bTrocoValid), 0);
    bEstados = ESPERA;
    step();
    chk("b_ocupado", int'(bOcupado), 0);
    $display("seq saturation credito=%0d", bCredito);

    // Asynchronous reset while a change coin is being offered.
    trocoQ.delete(); atraso = 10; preco = 255; estados = COMPARADOR;
    step();
    moeda(MOEDA_50);
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (troco_valid) break;
      step();
    end
    chk("rst_troco_valid_antes", int'(troco_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_troco_valid", int'(troco_valid), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_credito", int'(credito), 0);
    chk("rst_ok", int'(OK), 0);
    estados = ESPERA;
    atraso  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("rst_idle_ocupado", int'(ocupado), 0);
    chk("rst_idle_troco", int'(troco_valid), 0);
    $display("seq async_reset done");

    run_txn(tabela[1], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
